sort_engine: RTL and testbench
==============================

Name: sort_engine

Overview:
- Parametrised streaming sorter; successor to the fixed-size sort datapath/control pair.
- Accepts up to DEPTH words over a valid/ready input stream and sorts them in place with odd-even transposition passes.
- Sorts ascending or descending, selected per job.
- Emits the sorted words over a valid/ready output stream, then returns to idle for the next job.

Parameters:
- DATA_W, 8, element width in bits; unsigned compare.
- DEPTH, 8, maximum elements per job; must be >= 2.
- CNT_W, $clog2(DEPTH+1), width of element/pass counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  engine can accept an input word.
- in_data_i  in  DATA_W  input word.
- in_last_i  in  1  marks the final word of a short job.
- mode_i  in  1  0 = ascending, 1 = descending; sampled on the first accepted word.
- out_valid_o  out  1  out_data_o holds a sorted word.
- out_ready_i  in  1  downstream accepts the word.
- out_data_o  out  DATA_W  sorted word.
- out_last_o  out  1  high with the final sorted word.
- busy_o  out  1  high in LOAD, SORT and DRAIN.
- done_o  out  1  one-cycle pulse after the final output handshake.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE; the register array, counters and mode register clear to 0.
  - in_ready_o=0 while rst_n=0.
  - out_valid_o, out_data_o, out_last_o, busy_o and done_o all reset to 0.
- Reset mid-operation abandons the job; no partial output is produced.
- Input handshake: a word transfers when in_valid_i&in_ready_o. in_ready_o=1 only in IDLE and LOAD.
- States: IDLE, LOAD, SORT, DRAIN.
- IDLE:
  - First transfer writes slot 0 and latches mode_i; count=1.
  - Goes to LOAD, or directly to SORT if in_last_i=1.
- LOAD:
  - Each transfer writes slot[count] and increments count.
  - Goes to SORT on the transfer that has in_last_i=1 or that makes count==DEPTH.
  - On that exit, n=count is stored.
  - Slots n..DEPTH-1 are filled with a sentinel: all-ones (ascending) or all-zeros (descending), so they settle at the tail.
- SORT:
  - Exactly DEPTH passes, one per cycle; in_ready_o=0.
  - Even pass p compares pairs (0,1),(2,3)...; odd pass compares (1,2),(3,4)...
  - A pair swaps when out of order for the latched mode. Equal values never swap.
  - After pass DEPTH-1, goes to DRAIN with idx=0.
- DRAIN:
  - out_valid_o=1; out_data_o=slot[idx]; out_last_o=(idx==n-1).
  - On out_valid_o&out_ready_i, idx increments.
  - On the handshake at idx==n-1, goes to IDLE and asserts done_o for the next cycle only.
- Stall: while out_ready_i=0, out_data_o and out_last_o hold stable.
- Latency: the first out_valid_o rises DEPTH+1 cycles after the final input transfer.
- Sentinel words are never output; exactly n words leave per job.
- n=1: the full sort still runs, then one word is output with out_last_o=1.
- in_valid_i outside IDLE/LOAD is ignored; no back-to-back job overlap.
- done_o and in_ready_o may be high in the same cycle; a transfer in that cycle starts the next job.

Optional Feature:
- Macro: SORT_EARLY_EXIT_EN.
- Defined:
  - A swap flag is kept per pass.
  - SORT terminates after two consecutive passes with no swap, or after DEPTH passes, whichever is first.
  - Minimum sort time: 2 cycles.
- Undefined: always DEPTH passes; latency is fixed as above.

Test Plan:
- DEPTH=8, DATA_W=8, load 5,3,8,1,9,2,7,4, mode=0, out_ready_i=1 -> out 1,2,3,4,5,7,8,9; out_last_o on 9; first out_valid_o 9 cycles after last accept; done_o one-cycle pulse.
- Same data, mode=1 -> out 9,8,7,5,4,3,2,1; exactly 8 outputs.
- Short job: 0xFF, 0x00, 0x10 with in_last_i on the third, mode=0 -> out 0x00,0x10,0xFF; out_last_o on 0xFF; no 4th word.
- Backpressure: job 1 data with out_ready_i toggling 1,0,1,0... -> out_data_o stable during stalls; order 1..9 intact; in_ready_o=0 until done_o.
- Reset pulse (rst_n=0) during SORT pass 3 -> all outputs 0 immediately; in_ready_o=1 after release; next job 5,3,8,1,9,2,7,4 sorts correctly.
- Presorted 1..8, mode=0 -> with SORT_EARLY_EXIT_EN, out_valid_o 3 cycles after last accept; without, 9 cycles; output 1..8 in both cases.

Source files
------------

// File: rtl/sort_engine.sv
// sort_engine: streaming odd-even transposition sorter.
// Loads up to DEPTH words, sorts them in place (ascending or descending per
// job), then drains them over a valid/ready output stream.
// Optional macro SORT_EARLY_EXIT_EN: end the sort after two consecutive
// passes without a swap instead of always running DEPTH passes.
module sort_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    input  logic              mode_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SORT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [DATA_W-1:0] slot_q [DEPTH];
    logic [DATA_W-1:0] slot_d [DEPTH];
    logic [DATA_W-1:0] sorted_c [DEPTH];
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0]  pass_q, pass_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              mode_q, mode_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              in_xfer_c;
    logic              out_xfer_c;
    logic              load_end_c;
    logic              sort_end_c;
    logic [CNT_W-1:0]  wr_idx_c;
    logic [CNT_W-1:0]  wr_cnt_c;
    logic [CNT_W-1:0]  rd_idx_c;
    logic [DATA_W-1:0] rd_data_c;
`ifdef SORT_EARLY_EXIT_EN
    logic              any_swap_c;
    logic              quiet_q, quiet_d;
`endif

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

    assign in_xfer_c  = in_valid_i & in_ready_q;
    assign out_xfer_c = out_valid_q & out_ready_i;
    assign wr_idx_c   = (state_q == S_IDLE) ? '0 : count_q;
    assign wr_cnt_c   = wr_idx_c + CNT_W'(1);
    assign load_end_c = in_last_i | (wr_cnt_c == CNT_W'(DEPTH));
    assign rd_idx_c   = out_valid_q ? (idx_q + CNT_W'(1)) : idx_q;

    // One compare-exchange pass over the pairs selected by the pass parity
    always_comb begin
        sorted_c = slot_q;
`ifdef SORT_EARLY_EXIT_EN
        any_swap_c = 1'b0;
`endif
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            if (1'(i) == pass_q[0]) begin
                if (mode_q ? (slot_q[i] < slot_q[i+1]) : (slot_q[i] > slot_q[i+1])) begin
                    sorted_c[i]   = slot_q[i+1];
                    sorted_c[i+1] = slot_q[i];
`ifdef SORT_EARLY_EXIT_EN
                    any_swap_c = 1'b1;
`endif
                end
            end
        end
    end

    // Sort termination: fixed pass count, optionally cut short when settled
    always_comb begin
`ifdef SORT_EARLY_EXIT_EN
        sort_end_c = (pass_q == CNT_W'(DEPTH - 1)) | (quiet_q & ~any_swap_c);
`else
        sort_end_c = (pass_q == CNT_W'(DEPTH - 1));
`endif
    end

    // Read mux for the drain side
    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == rd_idx_c) begin
                rd_data_c = slot_q[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_xfer_c) begin
                    state_d = in_last_i ? S_SORT : S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_xfer_c && load_end_c) begin
                    state_d = S_SORT;
                end
            end
            S_SORT: begin
                if (sort_end_c) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_xfer_c && out_last_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        slot_d      = slot_q;
        count_d     = count_q;
        n_d         = n_q;
        pass_d      = pass_q;
        idx_d       = idx_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
        quiet_d     = quiet_q;
`endif
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_IDLE) || (state_d == S_LOAD);

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (in_xfer_c) begin
                    if (state_q == S_IDLE) begin
                        mode_d = mode_i;
                    end
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (CNT_W'(i) == wr_idx_c) begin
                            slot_d[i] = in_data_i;
                        end
                    end
                    count_d = wr_cnt_c;
                    if (load_end_c) begin
                        n_d    = wr_cnt_c;
                        pass_d = '0;
                        idx_d  = '0;
`ifdef SORT_EARLY_EXIT_EN
                        quiet_d = 1'b0;
`endif
                        // Sentinels sink to the tail for the chosen direction
                        for (int unsigned i = 0; i < DEPTH; i++) begin
                            if (CNT_W'(i) >= wr_cnt_c) begin
                                slot_d[i] = mode_d ? '0 : '1;
                            end
                        end
                    end
                end
            end
            S_SORT: begin
                slot_d = sorted_c;
                pass_d = pass_q + CNT_W'(1);
`ifdef SORT_EARLY_EXIT_EN
                quiet_d = ~any_swap_c;
`endif
                if (sort_end_c) begin
                    idx_d = '0;
                end
            end
            S_DRAIN: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_data_c;
                    out_last_d  = (rd_idx_c == n_q - CNT_W'(1));
                end else if (out_ready_i) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        idx_d       = '0;
                        done_d      = 1'b1;
                    end else begin
                        idx_d      = rd_idx_c;
                        out_data_d = rd_data_c;
                        out_last_d = (rd_idx_c == n_q - CNT_W'(1));
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            count_q     <= '0;
            n_q         <= '0;
            pass_q      <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SORT_EARLY_EXIT_EN
            quiet_q     <= 1'b0;
`endif
        end else begin
            slot_q      <= slot_d;
            count_q     <= count_d;
            n_q         <= n_d;
            pass_q      <= pass_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SORT_EARLY_EXIT_EN
            quiet_q     <= quiet_d;
`endif
        end
    end

endmodule

// File: tb/tb_sort_engine.sv
// tb_sort_engine: directed self-checking bench for sort_engine (DEPTH=8, DATA_W=8).
module tb_sort_engine;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i = '0;
    logic              in_last_i = 1'b0;
    logic              mode_i = 1'b0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b1;
    logic [DATA_W-1:0] out_data_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;

    int total = 0;
    int bad   = 0;

    logic [7:0] job_a   [DEPTH] = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
    logic [7:0] exp_asc [DEPTH] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
    logic [7:0] exp_dsc [DEPTH] = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    logic [7:0] job_s   [DEPTH] = '{8'hFF, 8'h00, 8'h10, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    logic [7:0] exp_s   [DEPTH] = '{8'h00, 8'h10, 8'hFF, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0};
    logic [7:0] job_p   [DEPTH] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};

    sort_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .mode_i      (mode_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Push n words; returns #1 after the edge of the final transfer
    task automatic send_job(input logic [7:0] d [DEPTH], input int n, input logic mode);
        int w;
        for (int k = 0; k < n; k++) begin
            in_valid_i = 1'b1;
            in_data_i  = d[k];
            in_last_i  = (k == n - 1);
            mode_i     = mode;
            w = 0;
            while (!in_ready_o && w < 100) begin
                @(posedge clk); #1;
                w++;
            end
            if (w >= 100) check_eq("in_ready_timeout", 32'(w), 32'(0));
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Drain n words, optionally with alternating backpressure, and check done
    task automatic collect(input logic [7:0] e [DEPTH], input int n, input bit bp);
        int k;
        int g;
        k = 0;
        g = 0;
        while (k < n && g < 300) begin
            out_ready_i = bp ? (g % 2 == 0) : 1'b1;
            if (out_valid_o) begin
                check_eq($sformatf("data%0d", k), 32'(out_data_o), 32'(e[k]));
                check_eq($sformatf("last%0d", k), 32'(out_last_o), 32'(k == n - 1));
                check_eq("in_ready_drain", 32'(in_ready_o), 32'(0));
                if (out_ready_i) k++;
            end
            @(posedge clk); #1;
            g++;
        end
        if (k < n) check_eq("drain_timeout", 32'(k), 32'(n));
        check_eq("done_pulse", 32'(done_o), 32'(1));
        check_eq("valid_after", 32'(out_valid_o), 32'(0));
        check_eq("ready_after", 32'(in_ready_o), 32'(1));
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        check_eq("done_clear", 32'(done_o), 32'(0));
        check_eq("no_extra", 32'(out_valid_o), 32'(0));
        check_eq("busy_idle", 32'(busy_o), 32'(0));
    endtask

    initial begin
        int lat;

        // Reset values
        #1;
        check_eq("rst_ready", 32'(in_ready_o), 32'(0));
        check_eq("rst_valid", 32'(out_valid_o), 32'(0));
        check_eq("rst_data", 32'(out_data_o), 32'(0));
        check_eq("rst_last", 32'(out_last_o), 32'(0));
        check_eq("rst_busy", 32'(busy_o), 32'(0));
        check_eq("rst_done", 32'(done_o), 32'(0));
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_ready", 32'(in_ready_o), 32'(1));

        // Full job ascending
        send_job(job_a, 8, 1'b0);
        check_eq("sort_ready", 32'(in_ready_o), 32'(0));
        check_eq("sort_busy", 32'(busy_o), 32'(1));
        wait_valid(lat);
`ifndef SORT_EARLY_EXIT_EN
        check_eq("lat_asc", 32'(lat), 32'(9));
`endif
        collect(exp_asc, 8, 1'b0);

        // Full job descending
        send_job(job_a, 8, 1'b1);
        wait_valid(lat);
        collect(exp_dsc, 8, 1'b0);

        // Short job with all-ones word that must not be lost among sentinels
        send_job(job_s, 3, 1'b0);
        wait_valid(lat);
`ifndef SORT_EARLY_EXIT_EN
        check_eq("lat_short", 32'(lat), 32'(9));
`endif
        collect(exp_s, 3, 1'b0);

        // Backpressure
        send_job(job_a, 8, 1'b0);
        wait_valid(lat);
        collect(exp_asc, 8, 1'b1);

        // Reset in the middle of SORT
        send_job(job_a, 8, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("mid_busy", 32'(busy_o), 32'(1));
        rst_n = 1'b0;
        #1;
        check_eq("mrst_valid", 32'(out_valid_o), 32'(0));
        check_eq("mrst_busy", 32'(busy_o), 32'(0));
        check_eq("mrst_ready", 32'(in_ready_o), 32'(0));
        check_eq("mrst_done", 32'(done_o), 32'(0));
        check_eq("mrst_data", 32'(out_data_o), 32'(0));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("mrst_ready_rel", 32'(in_ready_o), 32'(1));
        check_eq("mrst_novalid", 32'(out_valid_o), 32'(0));
        send_job(job_a, 8, 1'b0);
        wait_valid(lat);
        collect(exp_asc, 8, 1'b0);

        // Presorted input: latency depends on early exit
        send_job(job_p, 8, 1'b0);
        wait_valid(lat);
`ifdef SORT_EARLY_EXIT_EN
        check_eq("lat_presorted", 32'(lat), 32'(3));
`else
        check_eq("lat_presorted", 32'(lat), 32'(9));
`endif
        collect(job_p, 8, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
